// File: rtl/csr_access.sv
// csr_access: sequential Zicsr access unit between execute and the CSR file.
// Accepts one CSR instruction at a time, reads the CSR, performs the
// read-modify-write for CSRRW/RS/RC (and immediate forms), then returns the
// old value or an illegal-instruction flag.
// Optional feature: define CSR_ACCESS_STRICT_EN to restrict the implemented
// CSR set to 0xB00, 0xB03, 0xB04, 0xB80, 0xB83, 0xB84.

package core_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int CSR_ADDR_WIDTH = 12;
endpackage

module csr_access #(
   parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
   parameter int CSR_ADDR_WIDTH = core_pkg::CSR_ADDR_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [2:0]                funct3_i,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
   input  logic [DATA_WIDTH-1:0]     rs1_data_i,
   input  logic [4:0]                uimm_i,
   input  logic                      rs1_zero_i,
   output logic                      resp_valid_o,
   input  logic                      resp_ready_i,
   output logic [DATA_WIDTH-1:0]     resp_data_o,
   output logic                      resp_illegal_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
   input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
   output logic                      csr_we_o,
   output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
   output logic [DATA_WIDTH-1:0]     csr_wdata_o
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                      state_q;
   logic [2:0]                  funct3_q;
   logic [CSR_ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]       op_q;
   logic [DATA_WIDTH-1:0]       old_q;
   logic                        zero_q;

   logic                        wr_req;
   logic                        implemented;
   logic                        illegal;
   logic [DATA_WIDTH-1:0]       wdata;

   // Decode of the latched request: write need, legality and write data.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      wr_req      = 1'b0;
      implemented = 1'b1;
      wdata       = '0;

      case (funct3_q[1:0])
         2'b01:          wr_req = 1'b1;
         2'b10, 2'b11:   wr_req = !zero_q;
         default:        wr_req = 1'b0;
      endcase

`ifdef CSR_ACCESS_STRICT_EN
      implemented = (addr_q == CSR_ADDR_WIDTH'(12'hB00)) ||
                    (addr_q == CSR_ADDR_WIDTH'(12'hB03)) ||
                    (addr_q == CSR_ADDR_WIDTH'(12'hB04)) ||
                    (addr_q == CSR_ADDR_WIDTH'(12'hB80)) ||
                    (addr_q == CSR_ADDR_WIDTH'(12'hB83)) ||
                    (addr_q == CSR_ADDR_WIDTH'(12'hB84));
`else
      implemented = 1'b1;
`endif

      // Top two address bits 11 mark a read-only CSR.
      illegal = (funct3_q[1:0] == 2'b00) || !implemented ||
                (wr_req && (addr_q[CSR_ADDR_WIDTH-1 -: 2] == 2'b11));

      case (funct3_q[1:0])
         2'b01:   wdata = op_q;
         2'b10:   wdata = csr_rdata_i | op_q;
         default: wdata = csr_rdata_i & ~op_q;
      endcase
   end

   // Access FSM with registered handshake and CSR-file outputs.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst_i) begin
         state_q        <= IDLE;
         funct3_q       <= '0;
         addr_q         <= '0;
         op_q           <= '0;
         old_q          <= '0;
         zero_q         <= 1'b0;
         req_ready_o    <= 1'b1;
         resp_valid_o   <= 1'b0;
         resp_data_o    <= '0;
         resp_illegal_o <= 1'b0;
         csr_raddr_o    <= '0;
         csr_we_o       <= 1'b0;
         csr_waddr_o    <= '0;
         csr_wdata_o    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  funct3_q    <= funct3_i;
                  addr_q      <= csr_addr_i;
                  op_q        <= funct3_i[2] ? DATA_WIDTH'(uimm_i) : rs1_data_i;
                  zero_q      <= funct3_i[2] ? (uimm_i == 5'd0) : rs1_zero_i;
                  csr_raddr_o <= csr_addr_i;
                  req_ready_o <= 1'b0;
                  state_q     <= READ;
               end
            end
            READ: begin
               old_q       <= csr_rdata_i;
               csr_raddr_o <= '0;
               if (!illegal && wr_req) begin
                  csr_we_o    <= 1'b1;
                  csr_waddr_o <= addr_q;
                  csr_wdata_o <= wdata;
                  state_q     <= WRITE;
               end else begin
                  resp_valid_o   <= 1'b1;
                  resp_illegal_o <= illegal;
                  resp_data_o    <= illegal ? '0 : csr_rdata_i;
                  state_q        <= RESP;
               end
            end
            WRITE: begin
               csr_we_o       <= 1'b0;
               csr_waddr_o    <= '0;
               csr_wdata_o    <= '0;
               resp_valid_o   <= 1'b1;
               resp_illegal_o <= 1'b0;
               resp_data_o    <= old_q;
               state_q        <= RESP;
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o   <= 1'b0;
                  resp_illegal_o <= 1'b0;
                  resp_data_o    <= '0;
                  req_ready_o    <= 1'b1;
                  state_q        <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
